// File: rtl/i2s_stereo_receiver_pkg.sv
// Shared constants for the I2S stereo receiver: channel codes, pairing FSM states, default widths.
// Pure definitions; no logic, no latency, no flow control.
package i2s_pkg;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam int I2S_SLOT_W   = 32;
    localparam int I2S_SAMPLE_W = 24;

    typedef enum logic {
        PAIR_WAIT_L = 1'b0,
        PAIR_WAIT_R = 1'b1
    } pair_state_t;

endpackage

// File: rtl/i2s_stereo_receiver_slot_deserializer.sv
// Shifts in SD, tracks WS edges and slot length; slot_* outputs are combinational in the edge cycle.
// No backpressure: the I2S source cannot be stalled, so every completed slot is reported exactly once.
module i2s_slot_deserializer
    import i2s_pkg::*;
#(
    parameter int SLOT_W   = I2S_SLOT_W,
    parameter int SAMPLE_W = I2S_SAMPLE_W
) (
    input  logic                i2s_clk,
    input  logic                reset,
    input  logic                sd,
    input  logic                ws,
    output logic                slot_done,
    output logic                slot_ok,
    output logic                slot_chan,
    output logic [SAMPLE_W-1:0] slot_data
);

    localparam int CNT_W = $clog2(SLOT_W + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOT_W - 1);

    logic              ws_r;
    logic              armed;
    logic              ws_edge;
    logic [CNT_W-1:0]  bit_cnt;
    // The MSB of a full slot only ever lives in sh_next, so the register holds SLOT_W-1 bits.
    logic [SLOT_W-2:0] sh;
    logic [SLOT_W-1:0] sh_next;

    assign sh_next   = {sh, sd};
    assign ws_edge   = (ws != ws_r);
    assign slot_done = ws_edge & armed;
    // Completed length is bit_cnt+1 because the LSB arrives on the edge itself.
    assign slot_ok   = (bit_cnt == CNT_FULL);
    assign slot_chan = ws_r;
    assign slot_data = sh_next[SLOT_W-1 -: SAMPLE_W];

    always_ff @(posedge i2s_clk) begin
        if (reset) begin
            ws_r    <= 1'b0;
            armed   <= 1'b0;
            bit_cnt <= '0;
            sh      <= '0;
        end else begin
            ws_r <= ws;
            sh   <= sh_next[SLOT_W-2:0];
            if (ws_edge) begin
                bit_cnt <= '0;
                armed   <= 1'b1;
            end else if (bit_cnt != CNT_MAX) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_stereo_receiver.sv
// Philips I2S stereo receiver: per-slot samples, L/R frame pairing, saturating framing-error count.
// Outputs register one cycle after the WS edge; no backpressure, consumers must take every pulse.
module i2s_stereo_receiver
    import i2s_pkg::*;
#(
    parameter int SLOT_W    = I2S_SLOT_W,
    parameter int SAMPLE_W  = I2S_SAMPLE_W,
    parameter int OUT_W     = 24,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 i2s_clk,
    input  logic                 reset,
    input  logic                 SD,
    input  logic                 WS,
    output logic                 SCK,
    output logic [OUT_W-1:0]     sample,
    output logic                 sample_chan,
    output logic                 sample_valid,
    output logic [OUT_W-1:0]     frame_left,
    output logic [OUT_W-1:0]     frame_right,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic                       slot_done;
    logic                       slot_ok;
    logic                       slot_chan;
    logic        [SAMPLE_W-1:0] slot_data;
    logic signed [SAMPLE_W-1:0] slot_signed;
    logic        [OUT_W-1:0]    sample_ext;
    logic        [OUT_W-1:0]    left_buf;
    pair_state_t                state;

    assign SCK         = i2s_clk;
    assign slot_signed = signed'(slot_data);
    assign sample_ext  = OUT_W'(slot_signed);

    i2s_slot_deserializer #(
        .SLOT_W   (SLOT_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_deser (
        .i2s_clk   (i2s_clk),
        .reset     (reset),
        .sd        (SD),
        .ws        (WS),
        .slot_done (slot_done),
        .slot_ok   (slot_ok),
        .slot_chan (slot_chan),
        .slot_data (slot_data)
    );

    always_ff @(posedge i2s_clk) begin
        if (reset) begin
            sample       <= '0;
            sample_chan  <= CH_LEFT;
            sample_valid <= 1'b0;
            frame_left   <= '0;
            frame_right  <= '0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            err_count    <= '0;
            left_buf     <= '0;
            state        <= PAIR_WAIT_L;
        end else begin
            sample_valid <= 1'b0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            if (slot_done) begin
                if (slot_ok) begin
                    sample       <= sample_ext;
                    sample_chan  <= slot_chan;
                    sample_valid <= 1'b1;
                    if (state == PAIR_WAIT_L) begin
                        // A right slot with no pending left is still emitted, just never paired.
                        if (slot_chan == CH_LEFT) begin
                            left_buf <= sample_ext;
                            state    <= PAIR_WAIT_R;
                        end
                    end else begin
                        if (slot_chan == CH_RIGHT) begin
                            frame_left  <= left_buf;
                            frame_right <= sample_ext;
                            frame_valid <= 1'b1;
                            state       <= PAIR_WAIT_L;
                        end else begin
                            left_buf <= sample_ext;
                        end
                    end
                end else begin
                    frame_err <= 1'b1;
                    if (err_count != '1) begin
                        err_count <= err_count + ERR_CNT_W'(1);
                    end
                    state <= PAIR_WAIT_L;
                end
            end
        end
    end

endmodule
